// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 single-precision multiplier with round-to-nearest-even,
// flush-to-zero, exception flags, valid/ready backpressure and a tag side-channel.
module fmul_pipe #(
   parameter int STAGES = 3,
   parameter int TAG_W  = 6
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      x1,
   input  logic [31:0]      x2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      y,
   output logic [TAG_W-1:0] out_tag,
   output logic             ovf,
   output logic             udf,
   output logic             nv
);

   localparam int NMID = (STAGES > 1) ? STAGES - 1 : 1;

   // Working set carried between stages; each stage fills in its own fields.
   typedef struct packed {
      logic               sign;
      logic signed [9:0]  exp;
      logic               special;
      logic [31:0]        spec_y;
      logic               nv;
      logic [23:0]        sa;
      logic [23:0]        sb;
      logic [36:0]        pph;
      logic [34:0]        ppl;
      logic [47:0]        prod;
      logic [22:0]        mant;
      logic               g;
      logic               r;
      logic               s;
      logic [TAG_W-1:0]   tag;
   } pipe_t;

   typedef struct packed {
      logic [31:0]      y;
      logic             ovf;
      logic             udf;
      logic             nv;
      logic [TAG_W-1:0] tag;
   } res_t;

   // Denormals are classified as zero, so no separate denormal path exists.
   function automatic pipe_t f_dec(logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] t);
      pipe_t o;
      logic  nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
      o      = '0;
      nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      inf_a  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      inf_b  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      zero_a = (a[30:23] == 8'h00);
      zero_b = (b[30:23] == 8'h00);
      o.sign = a[31] ^ b[31];
      o.exp  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
      o.sa   = {1'b1, a[22:0]};
      o.sb   = {1'b1, b[22:0]};
      o.tag  = t;
      if (nan_a || nan_b) begin
         o.special = 1'b1;
         o.spec_y  = 32'h7FC00000;
         o.nv      = (nan_a && !a[22]) || (nan_b && !b[22]);
      end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
         o.special = 1'b1;
         o.spec_y  = 32'h7FC00000;
         o.nv      = 1'b1;
      end else if (inf_a || inf_b) begin
         o.special = 1'b1;
         o.spec_y  = {o.sign, 8'hFF, 23'd0};
      end else if (zero_a || zero_b) begin
         o.special = 1'b1;
         o.spec_y  = {o.sign, 31'd0};
      end
      return o;
   endfunction

   function automatic pipe_t f_pp(pipe_t i);
      pipe_t o;
      o     = i;
      o.pph = 37'(i.sa) * 37'(i.sb[23:11]);
      o.ppl = 35'(i.sa) * 35'(i.sb[10:0]);
      return o;
   endfunction

   function automatic pipe_t f_sum(pipe_t i);
      pipe_t o;
      o      = i;
      o.prod = {i.pph, 11'd0} + 48'(i.ppl);
      return o;
   endfunction

   function automatic pipe_t f_norm(pipe_t i);
      pipe_t o;
      o = i;
      if (i.prod[47]) begin
         o.mant = i.prod[46:24];
         o.g    = i.prod[23];
         o.r    = i.prod[22];
         o.s    = |i.prod[21:0];
         o.exp  = i.exp + 10'sd1;
      end else begin
         o.mant = i.prod[45:23];
         o.g    = i.prod[22];
         o.r    = i.prod[21];
         o.s    = |i.prod[20:0];
      end
      return o;
   endfunction

   // A rounding carry leaves the low 23 bits clear, which is exactly 1.0 x 2^(e+1).
   function automatic res_t f_pack(pipe_t i);
      res_t              o;
      logic              up;
      logic [23:0]       rnd;
      logic signed [9:0] e;
      up    = i.g && (i.r || i.s || i.mant[0]);
      rnd   = {1'b0, i.mant} + 24'(up);
      e     = i.exp + (rnd[23] ? 10'sd1 : 10'sd0);
      o     = '0;
      o.tag = i.tag;
      if (i.special) begin
         o.y  = i.spec_y;
         o.nv = i.nv;
      end else if (e >= 10'sd255) begin
         o.y   = {i.sign, 8'hFF, 23'd0};
         o.ovf = 1'b1;
      end else if (e <= 10'sd0) begin
         o.y   = {i.sign, 31'd0};
         o.udf = 1'b1;
      end else begin
         o.y = {i.sign, e[7:0], rnd[22:0]};
      end
      return o;
   endfunction

   pipe_t            st_q [NMID];
   pipe_t            st_d [NMID];
   res_t             res_q;
   res_t             res_d;
   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] load;
   logic [STAGES-1:0] vin;

   if (STAGES == 2) begin : g_s2
      assign st_d[0] = f_sum(f_pp(f_dec(x1, x2, in_tag)));
      assign res_d   = f_pack(f_norm(st_q[0]));
   end else if (STAGES == 3) begin : g_s3
      assign st_d[0] = f_dec(x1, x2, in_tag);
      assign st_d[1] = f_sum(f_pp(st_q[0]));
      assign res_d   = f_pack(f_norm(st_q[1]));
   end else if (STAGES == 4) begin : g_s4
      assign st_d[0] = f_pp(f_dec(x1, x2, in_tag));
      assign st_d[1] = f_sum(st_q[0]);
      assign st_d[2] = f_norm(st_q[1]);
      assign res_d   = f_pack(st_q[2]);
   end else begin : g_bad
      $error("fmul_pipe: STAGES must be 2, 3 or 4");
   end

   // A stage may advance when it is empty or its successor advances this cycle.
   always_comb begin
      logic chain;
      load  = '0;
      chain = !vld[STAGES-1] || out_ready;
      load[STAGES-1] = chain;
      for (int k = STAGES - 2; k >= 0; k--) begin
         chain   = !vld[k] || chain;
         load[k] = chain;
      end
   end

   assign vin = {vld[STAGES-2:0], in_valid};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld   <= '0;
         res_q <= '0;
         for (int k = 0; k < NMID; k++) st_q[k] <= '0;
      end else begin
         for (int k = 0; k < NMID; k++) begin
            if (load[k]) begin
               vld[k] <= vin[k];
               if (vin[k]) st_q[k] <= st_d[k];
            end
         end
         if (load[STAGES-1]) begin
            vld[STAGES-1] <= vin[STAGES-1];
            if (vin[STAGES-1]) res_q <= res_d;
         end
      end
   end

   assign in_ready  = load[0];
   assign out_valid = vld[STAGES-1];
   assign y         = res_q.y;
   assign out_tag   = res_q.tag;
   assign ovf       = res_q.ovf;
   assign udf       = res_q.udf;
   assign nv        = res_q.nv;

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Parametrised, fully pipelined IEEE-754 single-precision multiplier with valid/ready flow control and a tag side-channel.
- Next generation of the combinational/stepwise FPU multiplier. Adds round-to-nearest-even, special-value handling, exception flags, configurable depth and backpressure.
- Sits in the FPU execute path between the issue logic and the writeback arbiter. Tags carry the destination register ID.

Parameters:
- STAGES, 3, pipeline depth, legal values 2, 3 or 4; any other value is an elaboration error.
- TAG_W, 6, width of the pass-through tag.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the operand pair this cycle.
- x1  in  32  operand A (IEEE single).
- x2  in  32  operand B (IEEE single).
- in_tag  in  TAG_W  tag accompanying the operands.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- y  out  32  product.
- out_tag  out  TAG_W  tag of the result.
- ovf  out  1  overflow flag, qualified by out_valid.
- udf  out  1  underflow / flush-to-zero flag, qualified by out_valid.
- nv  out  1  invalid-operation flag, qualified by out_valid.

Behaviour:
- Reset (async assert, sync release): every stage valid bit is 0. out_valid, y, out_tag, ovf, udf and nv are all 0. In-flight operations are discarded and never emerge after reset releases.
- Handshake:
  - A transfer occurs when valid && ready on a given side.
  - Stage k loads when its valid bit is 0 or stage k+1 loads. The last stage loads when it is empty or out_ready=1.
  - in_ready equals the stage-1 load condition. Bubbles collapse.
  - Once out_valid=1, y, out_tag and the flags hold stable until accepted.
- Latency and throughput: an operation accepted at cycle t appears with out_valid=1 at cycle t+STAGES when there is no stall. Throughput is 1 per cycle. Capacity is STAGES operations. Ordering is strictly in-order.
- Stage split:
  - STAGES=2: decode + 24x24 multiply | normalise + round + pack.
  - STAGES=3: decode | multiply | normalise/round/pack.
  - STAGES=4: decode + partial products (13-bit high / 11-bit low split) | partial-product sum | normalise | round/pack.
- Arithmetic:
  - sign = s1^s2.
  - Unbiased exponent sum e = e1+e2-127, held as 10-bit signed so no wrap occurs.
  - Significands are {1,frac}; the 48-bit product P is exact.
  - If P[47]=1: mantissa = P[46:24], e+1. Otherwise mantissa = P[45:23].
  - Round to nearest even using guard bit G, round bit R and sticky S (OR of the remaining bits).
  - A rounding carry out of the mantissa increments the exponent and clears the mantissa.
- Boundary cases:
  - Denormal inputs are treated as signed zero (flush-to-zero). No flag is raised for flushed inputs.
  - Final biased exponent >= 255: y = {sign, 0xFF, 0} (infinity), ovf=1.
  - Final biased exponent <= 0 for a non-zero finite product: y = {sign, 31'b0}, udf=1.
  - Either input NaN: y = 0x7FC00000. nv=1 only if a NaN input is signalling (frac[22]=0).
  - Infinity x zero: y = 0x7FC00000, nv=1.
  - Infinity x finite non-zero, or infinity x infinity: y = signed infinity, no flag.
  - Zero x finite: y = signed zero, no flag.
  - At most one of ovf/udf is set per result.
- Simultaneous events: a stall at the output combined with new input fills empty stages only. An item is never overwritten or duplicated.

Test Plan:
- STAGES=3, x1=0x3FC00000, x2=0x40000000 at cycle 0, out_ready=1 -> out_valid at cycle 3, y=0x40400000, all flags 0, out_tag echoed.
- Tie rounding: x1=0x3F800001, x2=0x3FC00000 -> y=0x3FC00002 (tie rounds to even). x1=x2=0x3F800001 -> y=0x3F800002.
- Exceptions:
  - 0x7F000000 x 0x7F000000 -> y=0x7F800000, ovf=1.
  - 0x00800000 x 0x3F000000 -> y=0x00000000, udf=1.
  - 0x7F800000 x 0x80000000 -> y=0x7FC00000, nv=1.
  - 0xFF800000 x 0x40000000 -> y=0xFF800000, no flag.
- Backpressure: out_ready=0, 5 back-to-back ops with tags 1..5 -> in_ready drops after exactly STAGES accepts. Then release out_ready -> all 5 results arrive in tag order, none lost or duplicated.
- Random stall: out_ready toggled pseudo-randomly over 10k ops versus a reference model (RNE, FTZ) -> bit-exact y and flags. Repeat for STAGES=2 and STAGES=4.
- Reset mid-stream: assert rstn low with 3 ops in flight -> out_valid=0 immediately. After release, no stale results appear, and the first new op returns after STAGES cycles.
